joystick_dir_ctrl: RTL and testbench

JOYSTICK_DIR_CTRL -- requirements
Module: joystick_dir_ctrl

---
 rtl/snake_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/joystick_dir_ctrl.sv | 112 +++++++++++
 tb/tb_joystick_dir_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Direction codes and controller types shared by the joystick controller,
// the game logic and VGA_Pattern.
package snake_pkg;

  localparam int DIR_W = 2;

  typedef enum logic [DIR_W-1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } ctrl_state_t;

  // A turn is illegal if it repeats the reference heading or reverses it;
  // opposite directions differ only in bit 1 of the encoding.
  function automatic logic is_blocked(dir_t req_dir, dir_t ref_dir);
    return (req_dir == ref_dir) || (req_dir == dir_t'(ref_dir ^ 2'b10));
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debouncer for one raw push button;
// rise pulses for one cycle when the debounced level goes high.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // The counter tracks how long the synchronized input has disagreed with
  // the accepted level; any agreement restarts the wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      rise <= 1'b0;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_2;
        rise  <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/joystick_dir_ctrl.sv
// Joystick direction controller: debounces four buttons, filters illegal
// turns and commits the newest legal request on each snake step.
module joystick_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_right,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             move_tick,
  output logic [DIR_W-1:0] dir,
  output logic             dir_changed,
  output logic             pending_valid
);

  logic [3:0]  btn_raw;
  logic [3:0]  btn_rise;
  logic [3:0]  unused_level;

  ctrl_state_t state;
  ctrl_state_t state_next;
  dir_t        dir_q;
  dir_t        pend_dir;
  dir_t        req_dir;
  dir_t        ref_dir;
  logic        req_valid;
  logic        accept;
  logic        load_pend;
  logic        commit;

  assign btn_raw = {btn_left, btn_down, btn_right, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(unused_level[i]),
      .rise (btn_rise[i])
    );
  end

  // Bit order of btn_rise matches the direction encoding, so the lowest
  // set bit wins: UP > RIGHT > DOWN > LEFT.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_UP;
    if (btn_rise[0])      req_dir = DIR_UP;
    else if (btn_rise[1]) req_dir = DIR_RIGHT;
    else if (btn_rise[2]) req_dir = DIR_DOWN;
    else if (btn_rise[3]) req_dir = DIR_LEFT;
    else                  req_valid = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // On a committing step the new request is judged against the heading
  // being committed, not the one currently on dir.
  always_comb begin
    state_next = state;
    load_pend  = 1'b0;
    commit     = 1'b0;
    ref_dir    = dir_q;
    if (state == ST_PENDING && move_tick) ref_dir = pend_dir;
    accept = req_valid && !is_blocked(req_dir, ref_dir);
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load_pend  = 1'b1;
          state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (move_tick) begin
          commit = 1'b1;
          if (accept) load_pend  = 1'b1;
          else        state_next = ST_IDLE;
        end else if (accept) begin
          load_pend = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q       <= DIR_RESET;
      pend_dir    <= DIR_RESET;
      dir_changed <= 1'b0;
    end else begin
      dir_changed <= commit;
      if (commit)    dir_q    <= pend_dir;
      if (load_pend) pend_dir <= req_dir;
    end
  end

  assign dir           = dir_q;
  assign pending_valid = (state == ST_PENDING);

endmodule

// File: tb/tb_joystick_dir_ctrl.sv
// Self-checking bench for joystick_dir_ctrl: a behavioural model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_joystick_dir_ctrl;

  localparam int D = 4;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       move_tick = 1'b0;
  logic [3:0] btns      = 4'b0000;
  logic [1:0] dir;
  logic       dir_changed;
  logic       pending_valid;

  int checks   = 0;
  int failures = 0;

  logic [3:0] hist[$];
  logic [3:0] m_level;
  logic [3:0] m_rise;
  logic [3:0] samp;
  int         m_dir;
  int         m_pend;
  int         m_req;
  int         m_ref;
  bit         m_acc;
  bit         m_stable;
  bit         m_pv;
  bit         m_changed;
  int         n;

  joystick_dir_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_up       (btns[0]),
    .btn_right    (btns[1]),
    .btn_down     (btns[2]),
    .btn_left     (btns[3]),
    .move_tick    (move_tick),
    .dir          (dir),
    .dir_changed  (dir_changed),
    .pending_valid(pending_valid)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a button level is accepted once the raw input, seen two cycles
  // late through the synchronizer, has held a new value for D samples.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_front(4'b0000);
      m_level   = '0;
      m_rise    = '0;
      m_dir     = 1;
      m_pend    = 1;
      m_pv      = 0;
      m_changed = 0;
    end else begin
      m_changed = 0;
      m_req     = -1;
      for (int b = 0; b < 4; b++) if (m_rise[b] && m_req < 0) m_req = b;
      m_ref = (m_pv && move_tick) ? m_pend : m_dir;
      m_acc = (m_req >= 0) && (m_req != m_ref) && (m_req != (m_ref ^ 2));
      if (m_pv && move_tick) begin
        m_dir     = m_pend;
        m_changed = 1;
        if (m_acc) m_pend = m_req;
        else       m_pv   = 0;
      end else if (m_acc) begin
        m_pend = m_req;
        m_pv   = 1;
      end
      hist.push_front(btns);
      void'(hist.pop_back());
      m_rise = '0;
      for (int b = 0; b < 4; b++) begin
        m_stable = 1;
        samp     = hist[2];
        for (int k = 3; k <= D + 1; k++) begin
          if (hist[k][b] != samp[b]) m_stable = 0;
        end
        if (m_stable && samp[b] != m_level[b]) begin
          m_level[b] = samp[b];
          m_rise[b]  = samp[b];
        end
      end
    end
  end

  always @(negedge clk) begin
    check_output("model_dir", dir, m_dir);
    check_output("model_dir_changed", dir_changed, m_changed);
    check_output("model_pending_valid", pending_valid, m_pv);
  end

  task automatic apply_stimulus(input logic [3:0] mask);
    @(negedge clk);
    btns = btns | mask;
    repeat (D + 4) @(negedge clk);
    btns = btns & ~mask;
    repeat (D + 4) @(negedge clk);
  endtask

  task automatic do_tick();
    @(negedge clk);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
  endtask

  task automatic count_to_pending(output int cycles);
    cycles = 0;
    while (!pending_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_dir", dir, 1);
    check_output("reset_pending", pending_valid, 0);
    check_output("reset_changed", dir_changed, 0);
    reset = 1'b1;

    // Held UP: request 2+D cycles after the raw edge, pending one later.
    btns[0] = 1'b1;
    count_to_pending(n);
    check_output("up_latency", n, 7);
    repeat (3) @(negedge clk);
    do_tick();
    check_output("up_commit_dir", dir, 0);
    check_output("up_commit_pulse", dir_changed, 1);
    @(negedge clk);
    check_output("up_pulse_one_cycle", dir_changed, 0);
    btns[0] = 1'b0;
    repeat (D + 4) @(negedge clk);

    // Bouncing RIGHT never stays stable long enough.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      btns[1] = ~btns[1];
      repeat (2) @(negedge clk);
    end
    repeat (D + 4) @(negedge clk);
    check_output("bounce_no_request", pending_valid, 0);

    apply_stimulus(4'b0010);
    do_tick();
    check_output("to_right_dir", dir, 1);

    apply_stimulus(4'b1000);
    check_output("left_reversal_rejected", pending_valid, 0);
    apply_stimulus(4'b0100);
    apply_stimulus(4'b1000);
    check_output("down_kept_pending", pending_valid, 1);
    do_tick();
    check_output("down_commit_dir", dir, 2);

    apply_stimulus(4'b0010);
    do_tick();
    check_output("back_to_right", dir, 1);
    apply_stimulus(4'b0101);
    check_output("up_down_pending", pending_valid, 1);
    do_tick();
    check_output("up_priority_dir", dir, 0);

    // LEFT's request lands on the same edge as the committing tick.
    apply_stimulus(4'b0010);
    do_tick();
    apply_stimulus(4'b0100);
    @(negedge clk);
    btns[3] = 1'b1;
    repeat (6) @(negedge clk);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    check_output("coincide_dir", dir, 2);
    check_output("coincide_pending", pending_valid, 1);
    check_output("coincide_pulse", dir_changed, 1);
    btns[3] = 1'b0;
    repeat (D + 4) @(negedge clk);
    do_tick();
    check_output("coincide_second_dir", dir, 3);

    // Reset while PENDING with UP still held.
    @(negedge clk);
    btns[0] = 1'b1;
    repeat (D + 4) @(negedge clk);
    check_output("pre_reset_pending", pending_valid, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_output("midreset_dir", dir, 1);
    check_output("midreset_pending", pending_valid, 0);
    check_output("midreset_changed", dir_changed, 0);
    @(negedge clk);
    reset = 1'b1;
    count_to_pending(n);
    check_output("post_reset_latency", n, 7);
    do_tick();
    check_output("post_reset_commit", dir, 0);
    btns = 4'b0000;
    repeat (D + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
